// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared ISA opcodes, sequencer phases and decode helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int OPC_W   = 3;
  localparam int PHASE_W = 3;

  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_control_sequencer_if
//  Brief   : IR/ALU status inputs and datapath strobes of the sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
interface cpu_control_sequencer_if;
  import cpu_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic               sel;
  logic               rd;
  logic               ld_ir;
  logic               inc_pc;
  logic               ld_pc;
  logic               halt;
  logic               data_e;
  logic               ld_ac;
  logic               wr;
  logic [PHASE_W-1:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
  );

endinterface
`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_control_sequencer
//  Brief   : Eight-phase instruction sequencer driving PC/IR/ACC/memory strobes.
//  Rev     : 1.0  initial release
// ============================================================================
module cpu_control_sequencer
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  cpu_control_sequencer_if.master bus
);

  phase_e  r_phase;
  opcode_e r_opcode;
  logic    r_halted;

  phase_e  w_phase_nxt;
  logic    w_halted_nxt;
  logic    w_aluop;
  logic    w_hlt_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= INST_ADDR;
      r_opcode <= HLT;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
      if (r_phase == INST_LOAD)
        r_opcode <= opcode_e'(bus.opcode);
    end
  end

  always_comb begin
    w_aluop      = is_aluop(r_opcode);
    w_hlt_dec    = (r_phase == OP_ADDR) && (r_opcode == HLT);
    w_halted_nxt = r_halted | w_hlt_dec;
    // The phase freezes on the same edge that sets the sticky halt.
    w_phase_nxt  = (r_halted || w_hlt_dec) ? r_phase
                                           : phase_e'(r_phase + PHASE_W'(1));

    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.halt   = r_halted | w_hlt_dec;
    bus.phase  = r_phase;

    case (r_phase)
      INST_ADDR: begin
        bus.sel = 1'b1;
      end
      INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = ~w_hlt_dec;
      end
      OP_FETCH: begin
        bus.rd = w_aluop;
      end
      ALU_OP: begin
        bus.rd     = w_aluop;
        bus.inc_pc = ((r_opcode == SKZ) && bus.zero) || (r_opcode == JMP);
        bus.ld_pc  = (r_opcode == JMP);
        bus.data_e = (r_opcode == STO);
      end
      STORE: begin
        bus.rd     = w_aluop;
        bus.inc_pc = (r_opcode == JMP);
        bus.ld_pc  = (r_opcode == JMP);
        bus.data_e = (r_opcode == STO);
        bus.ld_ac  = w_aluop;
        bus.wr     = (r_opcode == STO);
      end
      default: begin
      end
    endcase

    if (r_halted) begin
      bus.sel    = 1'b0;
      bus.rd     = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.inc_pc = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.data_e = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.wr     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cpu_control_sequencer
//  Brief   : Directed table-driven bench for the eight-phase sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_control_sequencer;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpu_control_sequencer_if bus ();

  cpu_control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
  localparam logic [8:0] P0 = 9'b100000000;
  localparam logic [8:0] P1 = 9'b110000000;
  localparam logic [8:0] P2 = 9'b111000000;
  localparam logic [8:0] P4 = 9'b000100000;
  localparam logic [8:0] ZZ = 9'b000000000;
  localparam logic [8:0] HL = 9'b000001000;

  typedef struct {
    string             name;
    logic [2:0]        opc;
    logic              zero;
    logic [0:7][8:0]   exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [8:0] outs();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
            bus.halt, bus.data_e, bus.ld_ac, bus.wr};
  endfunction

  task automatic check(input string name, input int exp_ph, input logic [8:0] exp_o);
    checks++;
    if (int'(bus.phase) != exp_ph || outs() !== exp_o) begin
      errors++;
      $display("FAIL %s: got phase=%0d out=%b, expected phase=%0d out=%b",
               name, bus.phase, outs(), exp_ph, exp_o);
    end
  endtask

  // Leaves the DUT out of reset at a falling edge, sitting in phase 0.
  task automatic do_reset(input logic [2:0] opc, input logic z);
    rst = 1'b0;
    bus.opcode = opc;
    bus.zero   = z;
    repeat (2) @(negedge clk);
    #1;
    check("in_reset", 0, P0);
    rst = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;

    vecs[0] = '{"ADD",   3'd2, 1'b0, {P0, P1, P2, P2, P4, 9'b010000000, 9'b010000000, 9'b010000010}};
    vecs[1] = '{"STO",   3'd6, 1'b0, {P0, P1, P2, P2, P4, ZZ, 9'b000000100, 9'b000000101}};
    vecs[2] = '{"SKZ_z1", 3'd1, 1'b1, {P0, P1, P2, P2, P4, ZZ, 9'b000100000, ZZ}};
    vecs[3] = '{"SKZ_z0", 3'd1, 1'b0, {P0, P1, P2, P2, P4, ZZ, ZZ, ZZ}};
    vecs[4] = '{"JMP",   3'd7, 1'b0, {P0, P1, P2, P2, P4, ZZ, 9'b000110000, 9'b000110000}};
    vecs[5] = '{"LDA",   3'd5, 1'b1, {P0, P1, P2, P2, P4, 9'b010000000, 9'b010000000, 9'b010000010}};

    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].opc, vecs[v].zero);
      for (int rep = 0; rep < 2; rep++) begin
        for (int ph = 0; ph < 8; ph++) begin
          if (rep != 0 || ph != 0) @(negedge clk);
          #1;
          check(vecs[v].name, ph, vecs[v].exp[ph]);
        end
      end
    end

    // SKZ: zero pulsed only during OP_FETCH must not cause a skip.
    do_reset(3'd1, 1'b0);
    repeat (5) @(negedge clk);
    bus.zero = 1'b1;
    #1;
    check("skz_zero_ph5", 5, ZZ);
    @(negedge clk);
    bus.zero = 1'b0;
    #1;
    check("skz_zero_ph6", 6, ZZ);

    // JMP: IR changing to ADD mid-instruction is ignored.
    do_reset(3'd7, 1'b0);
    repeat (5) @(negedge clk);
    bus.opcode = 3'd2;
    #1;
    check("jmp_chg_ph5", 5, ZZ);
    @(negedge clk); #1;
    check("jmp_chg_ph6", 6, 9'b000110000);
    @(negedge clk); #1;
    check("jmp_chg_ph7", 7, 9'b000110000);

    // HLT: halt decodes in phase 4, then the phase stays frozen.
    do_reset(3'd0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("hlt_decode", 4, HL);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("hlt_frozen", 4, HL);
    end
    rst = 1'b0;
    #1;
    check("hlt_reset", 0, P0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("hlt_restart", 1, P1);

    // Asynchronous reset in STO phase 7 drops the write at once.
    do_reset(3'd6, 1'b0);
    repeat (7) @(negedge clk);
    #1;
    check("sto_ph7", 7, 9'b000000101);
    rst = 1'b0;
    #1;
    check("sto_async_rst", 0, P0);
    @(posedge clk); #1;
    check("sto_held_rst", 0, P0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("sto_release", 0, P0);
    @(negedge clk); #1;
    check("sto_after", 1, P1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
